// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory-side signals of
// mem_port_arbiter. The arbiter uses the slave view; the CPU/memory
// environment uses the master view.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_err;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        dm_err;
   logic [31:0] mem_dir;
   logic [31:0] mem_data_in;
   logic        mem_rd;
   logic        mem_wd;
   logic [31:0] mem_data_out;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
      output if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
             mem_dir, mem_data_in, mem_rd, mem_wd
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
      input  if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
             mem_dir, mem_data_in, mem_rd, mem_wd
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory between the fetch (IF) and load/store
// (DM) ports. Each access is a fixed IDLE -> ACCESS -> RESP sequence, so the
// memory strobes are single-cycle and the ack lands in the RESP cycle.
// DM has priority, but IF is forced through after STARVE_MAX consecutive DM
// grants taken while IF was waiting.
module mem_port_arbiter #(
   parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned STARVE_MAX = 3
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned CNT_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
   // 33-bit end bound so a range reaching the top of the address space cannot wrap
   localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(DEPTH) * 33'd4;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   starve_cnt;
   logic               lat_dm;
   logic               lat_we;
   logic               lat_err;

   logic               force_if;
   logic               pick_dm;
   logic               pick_if;
   logic [31:0]        sel_addr;
   logic               sel_err;
   logic               sel_we;
   logic [31:0]        resp_data;

   function automatic logic addr_err(input logic [31:0] a);
      return ({1'b0, a} < LO_ADDR) || ({1'b0, a} >= HI_ADDR) || (a[1:0] != 2'b00);
   endfunction

   // Winner selection and address check for the current IDLE cycle, plus
   // the read data that will be returned in RESP.
   always_comb begin
      force_if  = (starve_cnt == CNT_W'(STARVE_MAX)) && bus.if_req;
      pick_dm   = bus.dm_req && !force_if;
      pick_if   = bus.if_req && !pick_dm;
      sel_addr  = pick_dm ? bus.dm_addr : bus.if_addr;
      sel_we    = pick_dm && bus.dm_we;
      sel_err   = addr_err(sel_addr);
      resp_data = (lat_err || lat_we) ? '0 : bus.mem_data_out;
   end

   // Transaction FSM with all port and memory outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         starve_cnt      <= '0;
         lat_dm          <= 1'b0;
         lat_we          <= 1'b0;
         lat_err         <= 1'b0;
         bus.if_ack      <= 1'b0;
         bus.if_err      <= 1'b0;
         bus.if_rdata    <= '0;
         bus.dm_ack      <= 1'b0;
         bus.dm_err      <= 1'b0;
         bus.dm_rdata    <= '0;
         bus.mem_dir     <= '0;
         bus.mem_data_in <= '0;
         bus.mem_rd      <= 1'b0;
         bus.mem_wd      <= 1'b0;
      end else begin
         bus.if_ack <= 1'b0;
         bus.dm_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_dm || pick_if) begin
                  state           <= ACCESS;
                  lat_dm          <= pick_dm;
                  lat_we          <= sel_we;
                  lat_err         <= sel_err;
                  bus.mem_dir     <= sel_addr;
                  bus.mem_data_in <= pick_dm ? bus.dm_wdata : '0;
                  bus.mem_rd      <= !sel_err && !sel_we;
                  bus.mem_wd      <= !sel_err && sel_we;
               end
               if (!bus.if_req || pick_if)
                  starve_cnt <= '0;
               else if (pick_dm && (starve_cnt != CNT_W'(STARVE_MAX)))
                  starve_cnt <= starve_cnt + 1'b1;
            end
            ACCESS: begin
               state      <= RESP;
               bus.mem_rd <= 1'b0;
               bus.mem_wd <= 1'b0;
               if (lat_dm) begin
                  bus.dm_ack   <= 1'b1;
                  bus.dm_err   <= lat_err;
                  bus.dm_rdata <= resp_data;
               end else begin
                  bus.if_ack   <= 1'b1;
                  bus.if_err   <= lat_err;
                  bus.if_rdata <= resp_data;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: a table of single transactions
// followed by hand-written contention, request-drop and mid-store reset cases.
module tb_mem_port_arbiter;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic clk = 1'b0;
   logic rst_n;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .BASE_ADDR (BASE),
      .DEPTH     (64),
      .STARVE_MAX(3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   // Memory model: 64 words, combinational read, preloaded while in reset.
   logic [31:0] mem [64];
   logic [31:0] moff;
   assign moff             = bus.mem_dir - BASE;
   assign bus.mem_data_out = mem[moff[7:2]];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
         mem[1]  <= 32'h0810_0006;
         mem[63] <= 32'h1234_5678;
      end else if (bus.mem_wd) begin
         mem[moff[7:2]] <= bus.mem_data_in;
      end
   end

   int total = 0;
   int bad   = 0;
   int viol  = 0;
   logic prev_strobe = 1'b0;

   // Strobe rules: never both high, never high two cycles running.
   always @(negedge clk) begin
      if (bus.mem_rd && bus.mem_wd) viol++;
      if (prev_strobe && (bus.mem_rd || bus.mem_wd)) viol++;
      prev_strobe = bus.mem_rd || bus.mem_wd;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        dm;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[13];

   // One transaction on one port, started from IDLE; returns in the next IDLE.
   task automatic run_vec(input int idx, input vec_t v);
      int   edges = 0;
      int   wdc = 0;
      int   rdc = 0;
      int   other = 0;
      logic got = 1'b0;
      logic [31:0] wdir = '0;
      logic [31:0] wdat = '0;
      logic [31:0] rd = '0;
      logic        er = 1'b0;
      if (v.dm) begin
         bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = v.addr;
      end
      while (!got && edges < 10) begin
         @(posedge clk); #1;
         edges++;
         if (bus.mem_wd) begin wdc++; wdir = bus.mem_dir; wdat = bus.mem_data_in; end
         if (bus.mem_rd) rdc++;
         if (v.dm ? bus.if_ack : bus.dm_ack) other++;
         if (v.dm ? bus.dm_ack : bus.if_ack) begin
            got = 1'b1;
            rd  = v.dm ? bus.dm_rdata : bus.if_rdata;
            er  = v.dm ? bus.dm_err : bus.if_err;
         end
      end
      bus.dm_req = 1'b0;
      bus.if_req = 1'b0;
      bus.dm_addr = 32'hFFFF_FFF0;
      bus.if_addr = 32'hFFFF_FFF0;
      bus.dm_wdata = 32'h5555_5555;
      chk($sformatf("v%0d ack_latency", idx), 32'(edges), 32'd2);
      chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
      chk($sformatf("v%0d err", idx), 32'(er), 32'(v.exp_err));
      chk($sformatf("v%0d wd_cycles", idx), 32'(wdc), 32'(!v.exp_err && v.we));
      chk($sformatf("v%0d rd_cycles", idx), 32'(rdc), 32'(!v.exp_err && !v.we));
      chk($sformatf("v%0d other_ack", idx), 32'(other), 32'd0);
      if (v.we && !v.exp_err) begin
         chk($sformatf("v%0d wr_dir", idx), wdir, v.addr);
         chk($sformatf("v%0d wr_data", idx), wdat, v.wdata);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d ack_pulse", idx), 32'(v.dm ? bus.dm_ack : bus.if_ack), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      logic [7:0] seq;
      int n;
      int cyc;
      int both;
      int acks;
      logic got;

      //           dm    we    addr           wdata          exp_rdata      err
      vecs[0]  = '{1'b0, 1'b0, 32'h0040_0004, 32'h0,         32'h0810_0006, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 32'h0040_0020, 32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0040_0020, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h003F_FFFC, 32'h0,         32'h0,         1'b1};
      vecs[4]  = '{1'b1, 1'b0, 32'h0040_0100, 32'h0,         32'h0,         1'b1};
      vecs[5]  = '{1'b1, 1'b0, 32'h0040_0002, 32'h0,         32'h0,         1'b1};
      vecs[6]  = '{1'b1, 1'b1, 32'h0040_0100, 32'h7777_7777, 32'h0,         1'b1};
      vecs[7]  = '{1'b1, 1'b0, 32'h0040_00FC, 32'h0,         32'h1234_5678, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 32'h0040_0000, 32'h0,         32'hA500_0000, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0040_0001, 32'h0,         32'h0,         1'b1};
      vecs[10] = '{1'b1, 1'b1, 32'h0040_00FC, 32'hCAFE_F00D, 32'h0,         1'b0};
      vecs[11] = '{1'b0, 1'b0, 32'h0040_00FC, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};

      rst_n = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst if_ack", 32'(bus.if_ack), 32'd0);
      chk("rst dm_ack", 32'(bus.dm_ack), 32'd0);
      chk("rst if_err", 32'(bus.if_err), 32'd0);
      chk("rst dm_err", 32'(bus.dm_err), 32'd0);
      chk("rst mem_rd", 32'(bus.mem_rd), 32'd0);
      chk("rst mem_wd", 32'(bus.mem_wd), 32'd0);
      chk("rst if_rdata", bus.if_rdata, 32'h0);
      chk("rst dm_rdata", bus.dm_rdata, 32'h0);
      chk("rst mem_dir", bus.mem_dir, 32'h0);
      chk("rst mem_data_in", bus.mem_data_in, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
      chk("if_rdata_hold", bus.if_rdata, 32'hCAFE_F00D);

      // Contention: both requests held, expect D D D I D D D I at 3-cycle spacing.
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0040_0008;
      bus.if_req = 1'b1; bus.if_addr = 32'h0040_0004;
      seq = '0; n = 0; cyc = 0; both = 0;
      while (n < 8 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.dm_ack && bus.if_ack) both++;
         if (bus.dm_ack) begin seq[n] = 1'b1; n++; end
         else if (bus.if_ack) begin seq[n] = 1'b0; n++; end
      end
      bus.dm_req = 1'b0; bus.if_req = 1'b0;
      chk("cont grants", 32'(n), 32'd8);
      chk("cont order", 32'(seq), 32'h77);
      chk("cont cycles", 32'(cyc), 32'd23);
      chk("cont both_ack", 32'(both), 32'd0);
      @(posedge clk); #1;

      // Request dropped during ACCESS still completes.
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0040_0008;
      @(posedge clk); #1;
      chk("drop mem_rd", 32'(bus.mem_rd), 32'd1);
      bus.dm_req = 1'b0; bus.dm_addr = 32'hFFFF_FFF0;
      got = 1'b0; cyc = 0;
      while (!got && cyc < 5) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.dm_ack) begin
            got = 1'b1;
            chk("drop rdata", bus.dm_rdata, 32'hA500_0002);
            chk("drop err", 32'(bus.dm_err), 32'd0);
         end
      end
      chk("drop ack_latency", 32'(cyc), 32'd1);
      @(posedge clk); #1;

      // Reset during ACCESS of a store: strobes and acks clear, no late ack.
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h0040_0010; bus.dm_wdata = 32'h1111_1111;
      @(posedge clk); #1;
      chk("rstmid mem_wd_before", 32'(bus.mem_wd), 32'd1);
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rstmid mem_wd", 32'(bus.mem_wd), 32'd0);
      chk("rstmid mem_rd", 32'(bus.mem_rd), 32'd0);
      chk("rstmid dm_ack", 32'(bus.dm_ack), 32'd0);
      rst_n = 1'b1;
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.dm_ack || bus.if_ack) acks++;
      end
      chk("rstmid late_ack", 32'(acks), 32'd0);
      run_vec(13, '{1'b1, 1'b0, 32'h0040_0008, 32'h0, 32'hA500_0002, 1'b0});

      chk("strobe_rules", 32'(viol), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
